noc_vc_output_arbiter: RTL and testbench

- Parametrised next-generation router output port: N input ports compete for one output link carrying CHANNELS virtual channels.
- Performs wormhole VC locking, round-robin switch arbitration and credit-based downstream flow control.
- Drives one registered output flit stage.
- Sits between the router crossbar transpose and the outgoing link, one instance per active router port.

---
 rtl/noc_vc_output_arbiter_pkg.sv | 19 +
 rtl/noc_vc_output_arbiter_if.sv | 30 +++
 rtl/noc_vc_output_arbiter_rr_arbiter.sv | 44 ++++
 rtl/noc_vc_output_arbiter.sv | 156 +++++++++++++++
 tb/tb_noc_vc_output_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_vc_output_arbiter_pkg.sv
// Shared types and constants for the NoC output-port VC arbiter.
// Optional statistics counters are enabled with NOC_OUTPUT_ARB_STATS_EN.
package noc_vc_output_arbiter_pkg;

  localparam int unsigned NOC_MAX_INPUTS        = 8;
  localparam int unsigned NOC_DEFAULT_BUF_DEPTH = 4;
  localparam int unsigned OWNER_W               = 3;

  // Wormhole lock held by one input port on one output VC
  typedef struct packed {
    logic               locked;
    logic [OWNER_W-1:0] owner;
  } vc_lock_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_vc_output_arbiter_if.sv
// Crossbar-side flit handshake plus outgoing link/credit signals of one router output port.
interface noc_vc_output_arbiter_if #(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FLIT_W     = 64,
  parameter int unsigned VC_W       = noc_vc_output_arbiter_pkg::clog2_min1(CHANNELS)
);

  logic [NUM_INPUTS-1:0]        in_valid;
  logic [NUM_INPUTS*VC_W-1:0]   in_vc;
  logic [NUM_INPUTS-1:0]        in_sop;
  logic [NUM_INPUTS-1:0]        in_eop;
  logic [NUM_INPUTS*FLIT_W-1:0] in_flit;
  logic [NUM_INPUTS-1:0]        in_ready;
  logic                         out_valid;
  logic [VC_W-1:0]              out_vc;
  logic [FLIT_W-1:0]            out_flit;
  logic [CHANNELS-1:0]          credit_return;

  modport slave (
    input  in_valid, in_vc, in_sop, in_eop, in_flit, credit_return,
    output in_ready, out_valid, out_vc, out_flit
  );

  modport master (
    output in_valid, in_vc, in_sop, in_eop, in_flit, credit_return,
    input  in_ready, out_valid, out_vc, out_flit
  );

endinterface

// File: rtl/noc_vc_output_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searched from a registered pointer,
// pointer moves past the winner only when the grant is consumed (advance).
module noc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] request,
  output logic [NUM_REQ-1:0] grant,
  input  logic               advance
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] idx_c;
  logic [PTR_W-1:0] win_c;
  logic             found_c;

  // First requester at or after the pointer, wrapping
  always_comb begin
    grant   = '0;
    idx_c   = '0;
    win_c   = ptr_q;
    found_c = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found_c && request[idx_c]) begin
        found_c      = 1'b1;
        grant[idx_c] = 1'b1;
        win_c        = idx_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && found_c) begin
      ptr_q <= (win_c == PTR_W'(NUM_REQ - 1)) ? '0 : win_c + PTR_W'(1);
    end
  end

endmodule

// File: rtl/noc_vc_output_arbiter.sv
// Router output port: wormhole VC locking, round-robin switch arbitration,
// per-VC downstream credits and a registered output flit stage.
// Define NOC_OUTPUT_ARB_STATS_EN to add pkt_count/stall_count statistics ports.
module noc_vc_output_arbiter
  import noc_vc_output_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FLIT_W     = 64,
  parameter int unsigned BUF_DEPTH  = NOC_DEFAULT_BUF_DEPTH
) (
  input  logic                         noc_clk,
  input  logic                         noc_rst,
  noc_vc_output_arbiter_if.slave       bus,
  output logic [CHANNELS-1:0]          vc_busy,
  output logic                         credit_err
`ifdef NOC_OUTPUT_ARB_STATS_EN
  ,
  output logic [CHANNELS*16-1:0]       pkt_count,
  output logic [15:0]                  stall_count
`endif
);

  localparam int unsigned VC_W  = clog2_min1(CHANNELS);
  localparam int unsigned CRD_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IDX_W = clog2_min1(NUM_INPUTS);

  vc_lock_t          lock_q   [CHANNELS];
  logic [CRD_W-1:0]  credit_q [CHANNELS];

  logic [NUM_INPUTS-1:0] eligible_c;
  logic [NUM_INPUTS-1:0] request_c;
  logic [NUM_INPUTS-1:0] grant;
  logic                  xfer_c;
  logic [IDX_W-1:0]      win_idx_c;
  logic [VC_W-1:0]       win_vc_c;
  logic                  win_sop_c;
  logic                  win_eop_c;
  logic [FLIT_W-1:0]     win_flit_c;
  logic [CHANNELS-1:0]   send_c;

  logic                  out_valid_q;
  logic [VC_W-1:0]       out_vc_q;
  logic [FLIT_W-1:0]     out_flit_q;

  // A head may claim an idle VC; body/tail flits only follow their own lock
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
    logic [VC_W-1:0] vc;
    logic            vc_ok;
    assign vc = bus.in_vc[gi*VC_W +: VC_W];
    if (CHANNELS == (1 << VC_W)) begin : g_full
      assign vc_ok = 1'b1;
    end else begin : g_part
      assign vc_ok = (vc < VC_W'(CHANNELS));
    end
    assign eligible_c[gi] = bus.in_valid[gi] && vc_ok && (credit_q[vc] != '0) &&
                            (lock_q[vc].locked ? (lock_q[vc].owner == OWNER_W'(gi))
                                               : bus.in_sop[gi]);
  end

  assign request_c = eligible_c & {NUM_INPUTS{~noc_rst}};

  noc_rr_arbiter #(.NUM_REQ(NUM_INPUTS)) u_rr (
    .clk     (noc_clk),
    .rst     (noc_rst),
    .request (request_c),
    .grant   (grant),
    .advance (xfer_c)
  );

  assign xfer_c       = |grant;
  assign bus.in_ready = grant;

  always_comb begin
    win_idx_c = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) win_idx_c = IDX_W'(i);
    end
  end

  assign win_vc_c   = bus.in_vc[win_idx_c*VC_W +: VC_W];
  assign win_sop_c  = bus.in_sop[win_idx_c];
  assign win_eop_c  = bus.in_eop[win_idx_c];
  assign win_flit_c = bus.in_flit[win_idx_c*FLIT_W +: FLIT_W];

  always_comb begin
    send_c = '0;
    for (int unsigned v = 0; v < CHANNELS; v++) begin
      send_c[v] = xfer_c && (win_vc_c == VC_W'(v));
    end
  end

  // Output stage, VC locks and credit counters
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      out_valid_q <= 1'b0;
      out_vc_q    <= '0;
      out_flit_q  <= '0;
      credit_err  <= 1'b0;
      for (int unsigned v = 0; v < CHANNELS; v++) begin
        credit_q[v] <= CRD_W'(BUF_DEPTH);
        lock_q[v]   <= '0;
      end
    end else begin
      out_valid_q <= xfer_c;
      if (xfer_c) begin
        out_vc_q   <= win_vc_c;
        out_flit_q <= win_flit_c;
      end
      for (int unsigned v = 0; v < CHANNELS; v++) begin
        case ({send_c[v], bus.credit_return[v]})
          2'b10:   credit_q[v] <= credit_q[v] - CRD_W'(1);
          2'b01: begin
            if (credit_q[v] == CRD_W'(BUF_DEPTH)) credit_err  <= 1'b1;
            else                                  credit_q[v] <= credit_q[v] + CRD_W'(1);
          end
          default: ;
        endcase
        if (send_c[v]) begin
          if (lock_q[v].locked) begin
            if (win_eop_c) lock_q[v] <= '0;
          end else if (win_sop_c && !win_eop_c) begin
            lock_q[v] <= vc_lock_t'{locked: 1'b1, owner: OWNER_W'(win_idx_c)};
          end
        end
      end
    end
  end

  always_comb begin
    vc_busy = '0;
    for (int unsigned v = 0; v < CHANNELS; v++) vc_busy[v] = lock_q[v].locked;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_vc    = out_vc_q;
  assign bus.out_flit  = out_flit_q;

`ifdef NOC_OUTPUT_ARB_STATS_EN
  // Tail flits per VC (wrapping) and input-stall cycles (saturating)
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      for (int unsigned v = 0; v < CHANNELS; v++) begin
        if (send_c[v] && win_eop_c) pkt_count[v*16 +: 16] <= pkt_count[v*16 +: 16] + 16'd1;
      end
      if ((|bus.in_valid) && !xfer_c && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_vc_output_arbiter.sv
// Self-checking bench for noc_vc_output_arbiter: directed scenarios plus random
// legal traffic compared against a cycle-level behavioural model.
module tb_noc_vc_output_arbiter;

  localparam int NI = 5;
  localparam int CH = 2;
  localparam int FW = 64;
  localparam int BD = 4;
  localparam int VW = 1;

  logic noc_clk = 1'b0;
  logic noc_rst = 1'b0;
  logic [CH-1:0] vc_busy;
  logic          credit_err;
`ifdef NOC_OUTPUT_ARB_STATS_EN
  logic [CH*16-1:0] pkt_count;
  logic [15:0]      stall_count;
`endif

  noc_vc_output_arbiter_if #(.NUM_INPUTS(NI), .CHANNELS(CH), .FLIT_W(FW)) bus ();

  noc_vc_output_arbiter #(.NUM_INPUTS(NI), .CHANNELS(CH), .FLIT_W(FW), .BUF_DEPTH(BD)) dut (
    .noc_clk    (noc_clk),
    .noc_rst    (noc_rst),
    .bus        (bus),
    .vc_busy    (vc_busy),
    .credit_err (credit_err)
`ifdef NOC_OUTPUT_ARB_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .stall_count(stall_count)
`endif
  );

  always #5 noc_clk = ~noc_clk;

  int n_checks = 0;
  int n_fails  = 0;

  // stimulus presented this cycle
  bit            s_valid [NI];
  int            s_vc    [NI];
  bit            s_sop   [NI];
  bit            s_eop   [NI];
  logic [FW-1:0] s_flit  [NI];
  logic [CH-1:0] s_ret;

  // reference model: credits, lock owner (-1 = free), RR pointer, output stage
  int            m_credit [CH];
  int            m_owner  [CH];
  int            m_ptr;
  bit            m_err;
  bit            m_ov;
  int            m_ovc;
  logic [FW-1:0] m_oflit;

  // random upstream packet generators
  bit            g_active [NI];
  int            g_vc     [NI];
  int            g_len    [NI];
  int            g_idx    [NI];
  logic [FW-1:0] g_flit   [NI];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NI; i++) begin
      s_valid[i] = 0; s_vc[i] = 0; s_sop[i] = 0; s_eop[i] = 0; s_flit[i] = '0;
    end
    s_ret = '0;
  endtask

  task automatic set_in(input int i, input int vc, input bit sop, input bit eop, input logic [FW-1:0] f);
    s_valid[i] = 1; s_vc[i] = vc; s_sop[i] = sop; s_eop[i] = eop; s_flit[i] = f;
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      bus.in_valid[i]          = s_valid[i];
      bus.in_vc[i*VW +: VW]    = VW'(s_vc[i]);
      bus.in_sop[i]            = s_sop[i];
      bus.in_eop[i]            = s_eop[i];
      bus.in_flit[i*FW +: FW]  = s_flit[i];
    end
    bus.credit_return = s_ret;
  endtask

  task automatic model_reset();
    for (int v = 0; v < CH; v++) begin m_credit[v] = BD; m_owner[v] = -1; end
    for (int i = 0; i < NI; i++) g_active[i] = 0;
    m_ptr = 0; m_err = 0; m_ov = 0; m_ovc = 0; m_oflit = '0;
  endtask

  function automatic bit model_eligible(input int i);
    int v;
    v = s_vc[i];
    if (!s_valid[i] || m_credit[v] == 0) return 0;
    if (m_owner[v] == -1) return s_sop[i];
    return m_owner[v] == i;
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < NI; k++) begin
      if (model_eligible((m_ptr + k) % NI)) return (m_ptr + k) % NI;
    end
    return -1;
  endfunction

  task automatic model_update(input int w);
    for (int v = 0; v < CH; v++) begin
      bit send;
      send = (w >= 0) && (s_vc[w] == v);
      if (send && !s_ret[v]) m_credit[v]--;
      else if (!send && s_ret[v]) begin
        if (m_credit[v] == BD) m_err = 1;
        else m_credit[v]++;
      end
    end
    m_ov = (w >= 0);
    if (w >= 0) begin
      if (m_owner[s_vc[w]] == -1) begin
        if (s_sop[w] && !s_eop[w]) m_owner[s_vc[w]] = w;
      end else if (s_eop[w]) begin
        m_owner[s_vc[w]] = -1;
      end
      m_ptr   = (w + 1) % NI;
      m_ovc   = s_vc[w];
      m_oflit = s_flit[w];
    end
  endtask

  // one clock: present stimulus, check grant, clock, check registered outputs
  task automatic step(output int w);
    logic [CH-1:0] exp_busy;
    drive();
    @(negedge noc_clk);
    w = model_winner();
    check("in_ready", 64'(bus.in_ready), (w >= 0) ? (64'd1 << w) : 64'd0);
    @(posedge noc_clk);
    model_update(w);
    #1;
    check("out_valid", 64'(bus.out_valid), 64'(m_ov));
    if (m_ov) begin
      check("out_vc", 64'(bus.out_vc), 64'(m_ovc));
      check("out_flit", bus.out_flit, m_oflit);
    end
    for (int v = 0; v < CH; v++) exp_busy[v] = (m_owner[v] >= 0);
    check("vc_busy", 64'(vc_busy), 64'(exp_busy));
    check("credit_err", 64'(credit_err), 64'(m_err));
  endtask

  // async assert with current stimulus applied, release after the next edge
  task automatic do_reset();
    drive();
    noc_rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_vc_busy", 64'(vc_busy), 64'd0);
    check("rst_credit_err", 64'(credit_err), 64'd0);
    model_reset();
    @(posedge noc_clk);
    #1;
    noc_rst = 1'b0;
  endtask

  initial begin
    int w;
    int cnt;
    int exp_seq [4];
    int nxt [NI];

    clear_stim();
    #1;
    do_reset();

    // 3-flit packet from input 0 on VC0
    for (int f = 0; f < 3; f++) begin
      clear_stim();
      set_in(0, 0, f == 0, f == 2, 64'hA000 + 64'(f));
      step(w);
      check("t1_winner", 64'(w), 64'd0);
      if (f == 0) check("t1_busy_head", 64'(vc_busy[0]), 64'd1);
      if (f == 2) check("t1_busy_tail", 64'(vc_busy[0]), 64'd0);
    end

    // inputs 1 and 3 contend for VC0; 3 waits for 1's tail
    clear_stim(); do_reset();
    set_in(1, 0, 1, 0, 64'hB1); set_in(3, 0, 1, 0, 64'hB3);
    step(w); check("t2_first", 64'(w), 64'd1);
    set_in(1, 0, 0, 1, 64'hB2);
    step(w); check("t2_tail_owner", 64'(w), 64'd1);
    s_valid[1] = 0;
    step(w); check("t2_second", 64'(w), 64'd3);
    set_in(3, 0, 0, 1, 64'hB4);
    step(w); check("t2_second_tail", 64'(w), 64'd3);

    // two VCs interleave flit by flit
    clear_stim(); do_reset();
    exp_seq = '{0, 2, 0, 2};
    nxt[0] = 0; nxt[2] = 0;
    for (int c = 0; c < 4; c++) begin
      clear_stim();
      if (nxt[0] < 2) set_in(0, 0, nxt[0] == 0, nxt[0] == 1, 64'hC000 + 64'(nxt[0]));
      if (nxt[2] < 2) set_in(2, 1, nxt[2] == 0, nxt[2] == 1, 64'hC200 + 64'(nxt[2]));
      step(w);
      check("t3_order", 64'(w), 64'(exp_seq[c]));
      if (w >= 0) nxt[w]++;
    end

    // credit exhaustion on a 6-flit packet
    clear_stim(); do_reset();
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      set_in(0, 0, cnt == 0, cnt == 5, 64'hD000 + 64'(cnt));
      step(w);
      if (w == 0) cnt++;
    end
    check("t4_sent_on_credit", 64'(cnt), 64'd4);
    s_ret = 2'b01; step(w); check("t4_ret_no_send", 64'(w), -64'sd1);
    s_ret = 2'b00; step(w); check("t4_one_more", 64'(w), 64'd0);
    if (w == 0) cnt++;
    set_in(0, 0, 0, 1, 64'hD000 + 64'(cnt));
    step(w); check("t4_blocked_again", 64'(w), -64'sd1);
    s_ret = 2'b01; step(w);
    s_ret = 2'b01; step(w); check("t4_send_and_ret", 64'(w), 64'd0);
    s_ret = 2'b00;
    set_in(0, 0, 1, 1, 64'hD100);
    step(w); check("t4_count_kept", 64'(w), 64'd0);
    set_in(0, 0, 1, 1, 64'hD101);
    step(w); check("t4_empty", 64'(w), -64'sd1);

    // credit overflow is sticky and does not exceed depth
    clear_stim(); do_reset();
    s_ret = 2'b10; step(w);
    check("t5_err_set", 64'(credit_err), 64'd1);
    s_ret = 2'b00;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      set_in(1, 1, cnt == 0, cnt == 5, 64'hE000 + 64'(cnt));
      step(w);
      if (w == 1) cnt++;
    end
    check("t5_vc1_credits", 64'(cnt), 64'd4);
    check("t5_err_sticky", 64'(credit_err), 64'd1);

    // reset while VC0 is locked
    clear_stim(); do_reset();
    set_in(0, 0, 1, 0, 64'hF000);
    step(w); check("t6_locked", 64'(vc_busy[0]), 64'd1);
    set_in(0, 0, 0, 0, 64'hF001);
    do_reset();
    clear_stim();
    set_in(2, 0, 1, 1, 64'hF200);
    step(w); check("t6_new_owner", 64'(w), 64'd2);

    // random legal traffic
    clear_stim(); do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear_stim();
      for (int i = 0; i < NI; i++) begin
        if (!g_active[i] && ($urandom % 3 == 0)) begin
          g_active[i] = 1;
          g_vc[i]     = int'($urandom % CH);
          g_len[i]    = 1 + int'($urandom % 4);
          g_idx[i]    = 0;
          g_flit[i]   = {$urandom, $urandom};
        end
        if (g_active[i] && ($urandom % 4 != 0))
          set_in(i, g_vc[i], g_idx[i] == 0, g_idx[i] == g_len[i] - 1, g_flit[i]);
      end
      for (int v = 0; v < CH; v++) s_ret[v] = (m_credit[v] < BD) && ($urandom % 3 == 0);
      step(w);
      if (w >= 0) begin
        g_idx[w]++;
        g_flit[w] = {$urandom, $urandom};
        if (g_idx[w] == g_len[w]) g_active[w] = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
